keypad_scanner_rpt: RTL and testbench
=====================================

Name: keypad_scanner_rpt

Overview:
- Parametrised successor to the single-shot active-low key decoder used by the door-lock front end.
- Synchronises and debounces NUM_KEYS active-low key lines, then emits a one-cycle press pulse with the key code.
- Adds optional auto-repeat while a key is held, a release pulse, and multi-key rejection.
- Output feeds the password-entry FSM directly.

Parameters:
- NUM_KEYS, 9, number of active-low key inputs; key i (bit i) encodes as value i+1.
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples (>=1) required before the stable vector updates.
- REPEAT_DELAY, 500, cycles from the press pulse to the first repeat pulse (>=1).
- REPEAT_PERIOD, 100, cycles between subsequent repeat pulses (>=1).
- VAL_W, $clog2(NUM_KEYS+1), width of key_value (derived; do not override).

Ports:
- CLK  input  1  system clock.
- RESET_N  input  1  asynchronous, active-low reset.
- KEY  input  NUM_KEYS  raw key lines; 0 = pressed.
- REPEAT_EN  input  1  level; 1 enables auto-repeat; sampled every cycle.
- key_pulse  output  1  one-cycle strobe per accepted press or repeat.
- key_value  output  VAL_W  code of the last accepted key; holds between pulses.
- key_held  output  1  level; 1 while a valid single key is held.
- release_pulse  output  1  one-cycle strobe when a validly pressed key is released.
- multi_err  output  1  one-cycle strobe when more than one key is pressed.

Behaviour:
- Reset (async assert, sync release):
  - Sync FFs, candidate and stable vectors = all ones; counters = 0; FSM = IDLE.
  - key_pulse, key_held, release_pulse, multi_err = 0; key_value = 0.
- Sync: 2-FF chain on KEY, giving a synchronised vector sk.
- Debounce:
  - If sk != candidate: candidate <= sk, db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: stable <= candidate.
  - Else: db_cnt++.
  - The stable vector is the only input the FSM sees.
- FSM states: IDLE, HOLD, REPEAT, LOCK.
- IDLE:
  - stable all ones: remain in IDLE.
  - Exactly one zero at bit i: key_pulse=1 and key_value<=i+1 on the same edge, latch the pattern, tmr<=0, go to HOLD.
  - Two or more zeros: multi_err=1, go to LOCK.
- HOLD:
  - stable all ones: release_pulse=1, go to IDLE.
  - stable != latched pattern (not all ones): multi_err=1, go to LOCK. key_value is unchanged.
  - Else if REPEAT_EN and tmr == REPEAT_DELAY-1: key_pulse=1, tmr<=0, go to REPEAT.
  - Else: tmr++, saturating.
- REPEAT:
  - Release and pattern-change rules are identical to HOLD.
  - When tmr == REPEAT_PERIOD-1: key_pulse=1 with the same key_value, tmr<=0.
  - REPEAT_EN deasserted: no further pulses; stay until release.
- LOCK:
  - No pulses and key_held=0.
  - Go to IDLE when stable is all ones, with no release_pulse.
  - A key still held when LOCK is exited produces no pulse; a fresh press is required.
- key_held = 1 in HOLD and REPEAT, else 0.
- Pulse exclusivity: key_pulse, release_pulse and multi_err are never asserted in the same cycle.
- Latency: a clean press edge on KEY produces key_pulse exactly DEBOUNCE_CYCLES+3 cycles after the first CLK edge that samples it (2 sync + debounce + FSM register).
- Bounce: any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output.
- Counter widths: db_cnt and tmr are sized with $clog2 of their maximum value plus one; no wrap is permitted.
- Reset mid-hold: all outputs drop immediately. After release, a still-held key is re-debounced and produces a fresh press pulse.

Test Plan (bench params: NUM_KEYS=9, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Clean press/release: KEY[4]=0 held 10 cycles, then released -> one key_pulse with key_value=5 at edge 7 after the first sample; key_held high until release; release_pulse 7 cycles after the release edge; REPEAT_EN=0 -> no repeats.
- Bounce rejection: KEY[0] toggled low/high every 2 cycles for 20 cycles, then left high -> no pulses; key_value stays 0.
- Auto-repeat: REPEAT_EN=1, KEY[8] held 60 cycles -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52, all with key_value=9; release_pulse after release.
- Multi-key: KEY[1] pressed, then KEY[2] also low 10 cycles later -> press pulse with value 2, then multi_err; no pulse on release of KEY[2] alone; return to IDLE only when all keys are high.
- Simultaneous keys from idle: KEY=9'b111111100 -> multi_err only, key_value unchanged, no release_pulse.
- Reset mid-repeat: RESET_N low for 3 cycles during REPEAT -> all outputs 0 asynchronously; key still held after reset -> new key_pulse DEBOUNCE_CYCLES+3 cycles after reset release.

Source files
------------

// File: rtl/keypad_scanner_rpt_if.sv
// Key-scanner bundle: raw key lines and repeat enable in, press/release/error strobes out.
interface keypad_scanner_rpt_if #(
  parameter int NUM_KEYS = 9
) ();
  localparam int VAL_W = $clog2(NUM_KEYS + 1);

  logic [NUM_KEYS-1:0] key;
  logic                repeat_en;
  logic                key_pulse;
  logic [VAL_W-1:0]    key_value;
  logic                key_held;
  logic                release_pulse;
  logic                multi_err;

  modport master (
    output key, repeat_en,
    input  key_pulse, key_value, key_held, release_pulse, multi_err
  );

  modport slave (
    input  key, repeat_en,
    output key_pulse, key_value, key_held, release_pulse, multi_err
  );
endinterface

// File: rtl/keypad_scanner_rpt.sv
// Active-low keypad front end: 2-FF sync, debounce, single-key press/repeat/release
// strobes with multi-key lockout.
module keypad_scanner_rpt #(
  parameter int NUM_KEYS        = 9,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100,
  localparam int VAL_W          = $clog2(NUM_KEYS + 1)
) (
  input logic                 CLK,
  input logic                 RESET_N,
  keypad_scanner_rpt_if.slave bus
);

  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, cand_q, stable_q, latch_q;
  logic [DB_W-1:0]     db_cnt_q;
  logic [TMR_W-1:0]    tmr_q;
  state_t              state_q;
  logic                key_pulse_q, release_pulse_q, multi_err_q, key_held_q;
  logic [VAL_W-1:0]    key_value_q;

  logic [NUM_KEYS-1:0] pressed;
  logic                any_press, single_press;
  logic [VAL_W-1:0]    press_code;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      cand_q   <= '1;
      stable_q <= '1;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= bus.key;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q   <= sync2_q;
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        stable_q <= cand_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  // A power-of-two test on the pressed mask separates single presses from chords.
  always_comb begin
    pressed      = ~stable_q;
    any_press    = |pressed;
    single_press = any_press && ((pressed & (pressed - NUM_KEYS'(1))) == '0);
    press_code   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pressed[i]) press_code = VAL_W'(i + 1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= IDLE;
      latch_q         <= '1;
      tmr_q           <= '0;
      key_pulse_q     <= 1'b0;
      release_pulse_q <= 1'b0;
      multi_err_q     <= 1'b0;
      key_held_q      <= 1'b0;
      key_value_q     <= '0;
    end else begin
      key_pulse_q     <= 1'b0;
      release_pulse_q <= 1'b0;
      multi_err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (single_press) begin
            key_pulse_q <= 1'b1;
            key_value_q <= press_code;
            latch_q     <= stable_q;
            tmr_q       <= '0;
            key_held_q  <= 1'b1;
            state_q     <= HOLD;
          end else if (any_press) begin
            multi_err_q <= 1'b1;
            state_q     <= LOCK;
          end
        end
        HOLD, REPEAT: begin
          if (!any_press) begin
            release_pulse_q <= 1'b1;
            key_held_q      <= 1'b0;
            state_q         <= IDLE;
          end else if (stable_q != latch_q) begin
            multi_err_q <= 1'b1;
            key_held_q  <= 1'b0;
            state_q     <= LOCK;
          end else if (state_q == HOLD) begin
            if (bus.repeat_en && tmr_q == DELAY_LAST) begin
              key_pulse_q <= 1'b1;
              tmr_q       <= '0;
              state_q     <= REPEAT;
            end else if (tmr_q != DELAY_LAST) begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end else begin
            // Timer parks at the period limit so re-enabling repeat fires at once.
            if (bus.repeat_en && tmr_q == PERIOD_LAST) begin
              key_pulse_q <= 1'b1;
              tmr_q       <= '0;
            end else if (tmr_q != PERIOD_LAST) begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
        end
        LOCK: begin
          if (!any_press) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.key_pulse     = key_pulse_q;
  assign bus.key_value     = key_value_q;
  assign bus.key_held      = key_held_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.multi_err     = multi_err_q;

endmodule

// File: tb/tb_keypad_scanner_rpt.sv
// Directed bench for keypad_scanner_rpt; expected strobes are queued at stimulus
// time and matched cycle-exactly by a negedge monitor.
module tb_keypad_scanner_rpt;

  localparam int NK  = 9;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DEB + 4;  // drive just after edge N -> strobe visible after edge N+LAT

  localparam int K_NONE  = 0;
  localparam int K_PRESS = 1;
  localparam int K_REL   = 2;
  localparam int K_MULTI = 3;
  localparam int K_CLASH = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  ev_t  sb[$];
  int   obs_k, exp_k;

  keypad_scanner_rpt_if #(.NUM_KEYS(NK)) bus ();

  keypad_scanner_rpt #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int dc, input int kind, input int val);
    ev_t e;
    e.cyc  = cyc + dc;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
    $display("[%0d] queued kind=%0d value=%0d for cycle %0d", cyc, kind, val, e.cyc);
  endtask

  // Scoreboard: every strobe must coincide with the queued event for that cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_event", K_NONE, sb[0].kind);
        void'(sb.pop_front());
      end
      case ({bus.key_pulse, bus.release_pulse, bus.multi_err})
        3'b000:  obs_k = K_NONE;
        3'b100:  obs_k = K_PRESS;
        3'b010:  obs_k = K_REL;
        3'b001:  obs_k = K_MULTI;
        default: obs_k = K_CLASH;
      endcase
      exp_k = K_NONE;
      if (sb.size() > 0 && sb[0].cyc == cyc) exp_k = sb[0].kind;
      if (obs_k != K_NONE || exp_k != K_NONE) begin
        $display("[%0d] strobe kind=%0d value=%0d (expected kind=%0d)", cyc, obs_k, bus.key_value, exp_k);
        check("event_kind", obs_k, exp_k);
        if (exp_k != K_NONE) begin
          check("event_value", 32'(bus.key_value), sb[0].val);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.key       = '1;
    bus.repeat_en = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_key_pulse", 32'(bus.key_pulse), 0);
    check("rst_key_value", 32'(bus.key_value), 0);
    check("rst_key_held", 32'(bus.key_held), 0);
    check("rst_release", 32'(bus.release_pulse), 0);
    check("rst_multi", 32'(bus.multi_err), 0);
    step(3);
    rst_n = 1'b1;
    step(4);

    // Bounce on key 0: never stable for DEB samples
    for (int i = 0; i < 5; i++) begin
      bus.key[0] = 1'b0;
      step(2);
      bus.key[0] = 1'b1;
      step(2);
    end
    step(12);
    check("bounce_value", 32'(bus.key_value), 0);
    check("bounce_held", 32'(bus.key_held), 0);

    // Clean press/release of key 4, no repeat
    bus.key[4] = 1'b0;
    expect_ev(LAT, K_PRESS, 5);
    step(10);
    check("clean_held", 32'(bus.key_held), 1);
    check("clean_value", 32'(bus.key_value), 5);
    bus.key[4] = 1'b1;
    expect_ev(LAT, K_REL, 5);
    step(12);
    check("clean_released", 32'(bus.key_held), 0);

    // Auto-repeat on key 8
    bus.repeat_en = 1'b1;
    bus.key[8]    = 1'b0;
    expect_ev(LAT, K_PRESS, 9);
    expect_ev(LAT + RD, K_PRESS, 9);
    for (int k = 1; k <= 4; k++) expect_ev(LAT + RD + k * RP, K_PRESS, 9);
    step(60);
    check("repeat_held", 32'(bus.key_held), 1);
    bus.key[8] = 1'b1;
    expect_ev(LAT, K_REL, 9);
    step(12);
    bus.repeat_en = 1'b0;
    check("repeat_released", 32'(bus.key_held), 0);

    // Second key joins a held key -> lockout until all keys released
    bus.key[1] = 1'b0;
    expect_ev(LAT, K_PRESS, 2);
    step(10);
    bus.key[2] = 1'b0;
    expect_ev(LAT, K_MULTI, 2);
    step(12);
    check("multi_held", 32'(bus.key_held), 0);
    bus.key[2] = 1'b1;
    step(12);
    check("lock_partial_held", 32'(bus.key_held), 0);
    check("lock_value", 32'(bus.key_value), 2);
    bus.key[1] = 1'b1;
    step(12);
    bus.key[3] = 1'b0;
    expect_ev(LAT, K_PRESS, 4);
    step(12);
    check("after_lock_held", 32'(bus.key_held), 1);
    bus.key[3] = 1'b1;
    expect_ev(LAT, K_REL, 4);
    step(12);

    // Chord from idle
    bus.key = 9'b111111100;
    expect_ev(LAT, K_MULTI, 4);
    step(12);
    check("chord_held", 32'(bus.key_held), 0);
    check("chord_value", 32'(bus.key_value), 4);
    bus.key = '1;
    step(12);

    // Reset while repeating; key stays held through reset
    bus.repeat_en = 1'b1;
    bus.key[5]    = 1'b0;
    expect_ev(LAT, K_PRESS, 6);
    expect_ev(LAT + RD, K_PRESS, 6);
    step(30);
    check("pre_reset_held", 32'(bus.key_held), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_held", 32'(bus.key_held), 0);
    check("midrst_value", 32'(bus.key_value), 0);
    check("midrst_pulse", 32'(bus.key_pulse), 0);
    check("midrst_release", 32'(bus.release_pulse), 0);
    check("midrst_multi", 32'(bus.multi_err), 0);
    step(3);
    rst_n         = 1'b1;
    bus.repeat_en = 1'b0;
    expect_ev(LAT, K_PRESS, 6);
    step(12);
    check("postrst_held", 32'(bus.key_held), 1);
    check("postrst_value", 32'(bus.key_value), 6);
    bus.key[5] = 1'b1;
    expect_ev(LAT, K_REL, 6);
    step(12);

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
